condicionador_botoes: RTL and testbench

- Input conditioning stage directly upstream of the game datapath.
- Takes the four raw, asynchronous, bouncing push-buttons and synchronises, debounces and validates them.
- Produces a clean one-hot 4-bit level that feeds the datapath's `botoes` bus: held while the key is pressed, zero otherwise.
- Multi-key presses are rejected and flagged, so the datapath only ever sees legal one-hot plays.

---
 rtl/condicionador_botoes.sv | 117 +++++++++++
 tb/tb_condicionador_botoes.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/condicionador_botoes.sv
// Push-button conditioning: 2-flop synchroniser, debounce filter and one-hot
// validation feeding a clean, held play onto the game datapath's botoes bus.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   OCIOSO   | idle, waiting for a non-zero synchronised press (habilita=1)
//   FILTRA   | candidate must stay stable DEBOUNCE_CYCLES cycles
//   ATIVO    | valid one-hot play held on botoes
//   SOLTA    | waiting for a debounced full release before re-arming
//   INVALIDO | multi-key combination rejected, multiplo held
module condicionador_botoes #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] botoes_brutos,
  input  logic       habilita,
  output logic [3:0] botoes,
  output logic       pressionado,
  output logic       multiplo,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    FILTRA   = 4'd1,
    ATIVO    = 4'd2,
    SOLTA    = 4'd3,
    INVALIDO = 4'd4
  } estado_t;

  localparam logic [CNT_W-1:0] CNT_CARGA = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_UM    = CNT_W'(1);

  estado_t          estado;
  logic [3:0]       sync1;
  logic [3:0]       s;
  logic [3:0]       candidato;
  logic [CNT_W-1:0] cnt;
  logic             um_quente;

  assign um_quente = (candidato != 4'd0) && ((candidato & (candidato - 4'd1)) == 4'd0);
  assign db_estado = estado;

  // Debounce timer counts down from DEBOUNCE_CYCLES-1; terminal count is zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado      <= OCIOSO;
      sync1       <= 4'd0;
      s           <= 4'd0;
      candidato   <= 4'd0;
      cnt         <= '0;
      botoes      <= 4'd0;
      pressionado <= 1'b0;
      multiplo    <= 1'b0;
    end else begin
      sync1       <= botoes_brutos;
      s           <= sync1;
      pressionado <= 1'b0;
      case (estado)
        OCIOSO: begin
          if ((s != 4'd0) && habilita) begin
            candidato <= s;
            cnt       <= CNT_CARGA;
            estado    <= FILTRA;
          end
        end
        FILTRA: begin
          if (s == 4'd0) begin
            estado <= OCIOSO;
          end else if (s != candidato) begin
            candidato <= s;
            cnt       <= CNT_CARGA;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_UM;
          end else if (um_quente) begin
            estado      <= ATIVO;
            botoes      <= candidato;
            pressionado <= 1'b1;
          end else begin
            estado   <= INVALIDO;
            multiplo <= 1'b1;
          end
        end
        ATIVO: begin
          // Any change, release or an extra key, ends the play at once.
          if (s != candidato) begin
            cnt    <= CNT_CARGA;
            estado <= SOLTA;
            botoes <= 4'd0;
          end
        end
        INVALIDO: begin
          if (s == 4'd0) begin
            cnt      <= CNT_CARGA;
            estado   <= SOLTA;
            multiplo <= 1'b0;
          end
        end
        SOLTA: begin
          if (s != 4'd0) begin
            cnt <= CNT_CARGA;
          end else if (cnt == '0) begin
            estado <= OCIOSO;
          end else begin
            cnt <= cnt - CNT_UM;
          end
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes with DEBOUNCE_CYCLES=4; expected
// outputs are queued as each step is driven and compared after the clock edge.
module tb_condicionador_botoes;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] botoes_brutos;
  logic       habilita;
  logic [3:0] botoes;
  logic       pressionado;
  logic       multiplo;
  logic [3:0] db_estado;

  int vetores = 0;
  int erros   = 0;

  typedef struct {
    logic [3:0] botoes;
    logic       press;
    logic       mult;
    logic [3:0] est;
    string      tag;
  } esperado_t;

  esperado_t fila[$];

  condicionador_botoes #(.DEBOUNCE_CYCLES(D)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .botoes_brutos(botoes_brutos),
    .habilita     (habilita),
    .botoes       (botoes),
    .pressionado  (pressionado),
    .multiplo     (multiplo),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  task automatic compara(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vetores++;
    assert (obs === exp) else begin
      erros++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic confere_tudo(input string tag, input logic [3:0] eb, input logic ep,
                              input logic em, input logic [3:0] ee);
    compara({tag, ".botoes"}, botoes, eb);
    compara({tag, ".pressionado"}, {3'b0, pressionado}, {3'b0, ep});
    compara({tag, ".multiplo"}, {3'b0, multiplo}, {3'b0, em});
    compara({tag, ".db_estado"}, db_estado, ee);
  endtask

  // One clock step: drive inputs, queue expectation, then check after the edge.
  task automatic passo(input logic [3:0] raw, input logic hab, input logic [3:0] eb,
                       input logic ep, input logic em, input logic [3:0] ee, input string tag);
    esperado_t e;
    esperado_t r;
    botoes_brutos = raw;
    habilita      = hab;
    e.botoes = eb;
    e.press  = ep;
    e.mult   = em;
    e.est    = ee;
    e.tag    = tag;
    fila.push_back(e);
    @(posedge clock);
    #1;
    r = fila.pop_front();
    confere_tudo(r.tag, r.botoes, r.press, r.mult, r.est);
  endtask

  // Press held from idle: FILTRA from edge 3, decision on edge D+3.
  task automatic pressiona(input logic [3:0] raw, input int n, input string nome);
    logic       valido;
    logic [3:0] est;
    valido = ($countones(raw) == 1);
    for (int k = 1; k <= n; k++) begin
      if (k <= 2)          est = 4'd0;
      else if (k <= D + 2) est = 4'd1;
      else                 est = valido ? 4'd2 : 4'd4;
      passo(raw, 1'b1, (est == 4'd2) ? raw : 4'd0, (k == D + 3) && valido,
            (est == 4'd4), est, $sformatf("%s[%0d]", nome, k));
    end
  endtask

  // Release from ATIVO/INVALIDO: leaves on the 3rd edge, idle after SOLTA debounce.
  task automatic solta(input logic [3:0] prev, input logic [3:0] est_prev, input string nome);
    logic [3:0] est;
    for (int r = 1; r <= D + 4; r++) begin
      if (r <= 2)          est = est_prev;
      else if (r <= D + 2) est = 4'd3;
      else                 est = 4'd0;
      passo(4'd0, 1'b1, (est == 4'd2) ? prev : 4'd0, 1'b0, (est == 4'd4), est,
            $sformatf("%s[%0d]", nome, r));
    end
  endtask

  initial begin
    logic [3:0] est_b [17];
    logic [3:0] raw_v;
    logic [3:0] est;

    reset_n       = 1'b0;
    botoes_brutos = 4'd0;
    habilita      = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    confere_tudo("reset", 4'd0, 1'b0, 1'b0, 4'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) passo(4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, "idle");

    // 1: clean press
    pressiona(4'b0100, 20, "limpo");
    solta(4'b0100, 4'd2, "limpo_solta");

    // 2: bounce, last toggle on step 9
    est_b = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0,
              4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2};
    for (int j = 1; j <= 17; j++) begin
      if (j <= 10) raw_v = (((j - 1) / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
      else         raw_v = 4'b0010;
      est = est_b[j-1];
      passo(raw_v, 1'b1, (est == 4'd2) ? 4'b0010 : 4'd0, (j == 15), 1'b0, est,
            $sformatf("ressalto[%0d]", j));
    end
    solta(4'b0010, 4'd2, "ressalto_solta");

    // 3: multi-key rejected
    pressiona(4'b0011, 15, "multi");
    solta(4'b0000, 4'd4, "multi_solta");

    // 4: re-press while SOLTA is still debouncing the release
    pressiona(4'b1000, 10, "repress_a");
    for (int j = 1; j <= 19; j++) begin
      if (j <= 2)       raw_v = 4'b0000;
      else if (j <= 12) raw_v = 4'b1000;
      else              raw_v = 4'b0000;
      if (j <= 2)       est = 4'd2;
      else if (j <= 17) est = 4'd3;
      else              est = 4'd0;
      passo(raw_v, 1'b1, (est == 4'd2) ? 4'b1000 : 4'd0, 1'b0, 1'b0, est,
            $sformatf("repress_solta[%0d]", j));
    end
    pressiona(4'b1000, 9, "repress_b");
    solta(4'b1000, 4'd2, "repress_b_solta");

    // 5: habilita low blocks only the idle->filter step
    for (int j = 1; j <= 8; j++)
      passo(4'b0001, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, $sformatf("desab[%0d]", j));
    for (int m = 1; m <= 7; m++) begin
      est = (m <= D) ? 4'd1 : 4'd2;
      passo(4'b0001, 1'b1, (est == 4'd2) ? 4'b0001 : 4'd0, (m == D + 1), 1'b0, est,
            $sformatf("habilita[%0d]", m));
    end
    solta(4'b0001, 4'd2, "habilita_solta");

    // 6: asynchronous reset mid-play, key kept held afterwards
    pressiona(4'b0100, 9, "pre_reset");
    #3;
    reset_n = 1'b0;
    #1;
    confere_tudo("reset_async", 4'd0, 1'b0, 1'b0, 4'd0);
    @(posedge clock);
    #1;
    confere_tudo("reset_hold", 4'd0, 1'b0, 1'b0, 4'd0);
    reset_n = 1'b1;
    pressiona(4'b0100, 8, "pos_reset");
    solta(4'b0100, 4'd2, "pos_reset_solta");

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
